// File: rtl/aes_key_schedule_store_if.sv
// Handshake and key-bus bundle for aes_key_schedule_store.
// The zeroize wire exists only when KEYSCHED_ZEROIZE_EN is defined.
interface aes_key_schedule_store_if;
    logic         start;
    logic [0:127] key_in;
    logic         busy;
    logic         done;
    logic         key_ready;
    logic         rd_en;
    logic [0:3]   rd_round;
    logic [0:127] rk_out;
    logic         rk_valid;
`ifdef KEYSCHED_ZEROIZE_EN
    logic         zeroize;

    modport master (
        output start, key_in, rd_en, rd_round, zeroize,
        input  busy, done, key_ready, rk_out, rk_valid
    );
    modport slave (
        input  start, key_in, rd_en, rd_round, zeroize,
        output busy, done, key_ready, rk_out, rk_valid
    );
`else
    modport master (
        output start, key_in, rd_en, rd_round,
        input  busy, done, key_ready, rk_out, rk_valid
    );
    modport slave (
        input  start, key_in, rd_en, rd_round,
        output busy, done, key_ready, rk_out, rk_valid
    );
`endif
endinterface

// File: rtl/aes_key_schedule_store.sv
// AES-128 round-key scheduler: one expansion round per clock into an 11-entry bank,
// then indexed reads. Optional KEYSCHED_ZEROIZE_EN adds a synchronous key wipe.
module aes_key_schedule_store #(
    parameter int NROUNDS = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    aes_key_schedule_store_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXPAND, READY} state_e;

    state_e       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [0:127] slot_q [0:NROUNDS];
    logic [0:127] slot_d [0:NROUNDS];
    logic [0:127] rk_out_q, rk_out_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         key_ready_q, key_ready_d;
    logic         rk_valid_q, rk_valid_d;
    logic [3:0]   prev_idx;
    logic [127:0] next_rk;
    logic         zero_req;

`ifdef KEYSCHED_ZEROIZE_EN
    assign zero_req = bus.zeroize;
`else
    assign zero_req = 1'b0;
`endif

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (x^254) followed by the affine map; avoids a 256-entry ROM.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, inv;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        inv  = gf_mul(gf_mul(x240, x12), x2);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 1; i < 10; i++) begin
            if (4'(i) < rnd) r = xtime(r);
        end
        return r;
    endfunction

    function automatic logic [127:0] keygen(input logic [127:0] k, input logic [3:0] rnd);
        logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
        w0 = k[127:96];
        w1 = k[95:64];
        w2 = k[63:32];
        w3 = k[31:0];
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
             ^ {rcon(rnd), 24'h000000};
        n0 = w0 ^ t;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    assign prev_idx = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
    assign next_rk  = keygen(slot_q[prev_idx], cnt_q);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        slot_d     = slot_q;
        rk_out_d   = rk_out_q;
        rk_valid_d = 1'b0;
        done_d     = 1'b0;
        if (zero_req) begin
            state_d  = IDLE;
            cnt_d    = 4'd0;
            rk_out_d = '0;
            for (int i = 0; i <= NROUNDS; i++) slot_d[i] = '0;
        end else begin
            case (state_q)
                IDLE, READY: begin
                    // start outranks a simultaneous read; that read is dropped
                    if (bus.start) begin
                        slot_d[0] = bus.key_in;
                        cnt_d     = 4'd1;
                        state_d   = EXPAND;
                    end else if (state_q == READY && bus.rd_en) begin
                        rk_valid_d = 1'b1;
                        rk_out_d   = (bus.rd_round > 4'(NROUNDS)) ? '0 : slot_q[bus.rd_round];
                    end
                end
                EXPAND: begin
                    slot_d[cnt_q] = next_rk;
                    cnt_d         = cnt_q + 4'd1;
                    if (cnt_q == 4'(NROUNDS)) begin
                        state_d = READY;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        busy_d      = (state_d == EXPAND);
        key_ready_d = (state_d == READY);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            for (int i = 0; i <= NROUNDS; i++) slot_q[i] <= '0;
            rk_out_q    <= '0;
            rk_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            key_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            slot_q      <= slot_d;
            rk_out_q    <= rk_out_d;
            rk_valid_q  <= rk_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            key_ready_q <= key_ready_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.key_ready = key_ready_q;
    assign bus.rk_out    = rk_out_q;
    assign bus.rk_valid  = rk_valid_q;
endmodule

// File: tb/tb_aes_key_schedule_store.sv
// Directed plus randomized bench for aes_key_schedule_store with a word-level
// FIPS-197 key-expansion reference model built on a table S-box.
module tb_aes_key_schedule_store;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aes_key_schedule_store_if kif();
    aes_key_schedule_store #(.NROUNDS(10)) dut (.clk(clk), .rst(rst), .bus(kif.slave));

    int n_cmp  = 0;
    int n_fail = 0;
    logic [127:0] ref_rk [0:10];

    localparam logic [2047:0] SBOX_TBL = 2048'h637c777bf26b6fc53001672bfed7ab76_ca82c97dfa5947f0add4a2af9ca472c0_b7fd9326363ff7cc34a5e5f171d83115_04c723c31896059a071280e2eb27b275_09832c1a1b6e5aa0523bd6b329e32f84_53d100ed20fcb15b6acbbe394a4c58cf_d0efaafb434d338545f9027f503c9fa8_51a3408f929d38f5bcb6da2110fff3d2_cd0c13ec5f974417c4a77e3d645d1973_60814fdc222a908846eeb814de5e0bdb_e0323a0a4906245cc2d3ac629195e479_e7c8376d8dd54ea96c56f4ea657aae08_ba78252e1ca6b4c6e8dd741f4bbd8b8a_703eb5664803f60e613557b986c11d9e_e1f8981169d98e949b1e87e9ce5528df_8ca1890dbfe6426841992d0fb054bb16;

    function automatic logic [7:0] sb(input logic [7:0] x);
        logic [2047:0] t;
        t = SBOX_TBL;
        return t[2047 - 8 * int'(x) -: 8];
    endfunction

    task automatic model_expand(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {sb(t[23:16]), sb(t[15:8]), sb(t[7:0]), sb(t[31:24])} ^ {rc, 24'h000000};
                rc = rc[7] ? ({rc[6:0], 1'b0} ^ 8'h1b) : {rc[6:0], 1'b0};
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) ref_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_expand(input logic [127:0] k, input string tag);
        kif.key_in = k;
        kif.start  = 1'b1;
        step();
        kif.start  = 1'b0;
        chk1({tag, "_busy_t0"}, kif.busy, 1'b1);
        chk1({tag, "_ready_t0"}, kif.key_ready, 1'b0);
        for (int c = 1; c <= 10; c++) begin
            step();
            chk1($sformatf("%s_busy_t%0d", tag, c), kif.busy, c < 10);
            chk1($sformatf("%s_done_t%0d", tag, c), kif.done, c == 10);
        end
        chk1({tag, "_key_ready"}, kif.key_ready, 1'b1);
        model_expand(k);
    endtask

    task automatic do_read(input logic [3:0] r, input logic [127:0] exp_v, input string tag);
        kif.rd_en    = 1'b1;
        kif.rd_round = r;
        step();
        kif.rd_en    = 1'b0;
        chk1({tag, "_valid"}, kif.rk_valid, 1'b1);
        chk({tag, "_data"}, kif.rk_out, exp_v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] k, k_hold;
        logic [3:0]   r;

        rst          = 1'b1;
        kif.start    = 1'b0;
        kif.key_in   = '0;
        kif.rd_en    = 1'b0;
        kif.rd_round = 4'd0;
`ifdef KEYSCHED_ZEROIZE_EN
        kif.zeroize  = 1'b0;
`endif
        step();
        step();
        chk1("rst_busy", kif.busy, 1'b0);
        chk1("rst_done", kif.done, 1'b0);
        chk1("rst_key_ready", kif.key_ready, 1'b0);
        chk1("rst_rk_valid", kif.rk_valid, 1'b0);
        chk("rst_rk_out", kif.rk_out, 128'h0);
        rst = 1'b0;
        step();
        chk1("idle_key_ready", kif.key_ready, 1'b0);

        // Basic FIPS-197 A.1 vector
        run_expand(128'h2b7e151628aed2a6abf7158809cf4f3c, "basic");
        do_read(4'd1, 128'ha0fafe1788542cb123a339392a6c7605, "basic_rd1");
        chk1("basic_done_fall", kif.done, 1'b0);
        do_read(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "basic_rd10");
        do_read(4'd0, 128'h2b7e151628aed2a6abf7158809cf4f3c, "basic_rd0");
        step();
        chk1("hold_valid", kif.rk_valid, 1'b0);
        chk("hold_data", kif.rk_out, 128'h2b7e151628aed2a6abf7158809cf4f3c);

        // Reverse sweep at full throughput
        kif.rd_en = 1'b1;
        for (int i = 0; i <= 10; i++) begin
            kif.rd_round = 4'(10 - i);
            step();
            chk1($sformatf("sweep_valid_%0d", 10 - i), kif.rk_valid, 1'b1);
            chk($sformatf("sweep_data_%0d", 10 - i), kif.rk_out, ref_rk[10 - i]);
        end
        kif.rd_en = 1'b0;
        step();
        chk1("sweep_valid_end", kif.rk_valid, 1'b0);

        do_read(4'd12, 128'h0, "oor12");
        do_read(4'd15, 128'h0, "oor15");

        // Guards: reads and a stray start during expansion
        k = {$urandom, $urandom, $urandom, $urandom};
        kif.key_in = k;
        kif.start  = 1'b1;
        step();
        kif.start  = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            kif.rd_en    = 1'b1;
            kif.rd_round = 4'(c % 11);
            if (c == 4) begin
                kif.start  = 1'b1;
                kif.key_in = ~k;
            end
            step();
            kif.start = 1'b0;
            chk1($sformatf("guard_valid_t%0d", c), kif.rk_valid, 1'b0);
            chk1($sformatf("guard_done_t%0d", c), kif.done, c == 10);
        end
        kif.rd_en = 1'b0;
        model_expand(k);
        for (int i = 0; i < 4; i++) begin
            r = 4'($urandom_range(0, 10));
            do_read(r, ref_rk[r], $sformatf("guard_rd%0d", r));
        end

        // Randomized keys and read indices
        for (int n = 0; n < 4; n++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            run_expand(k, $sformatf("rnd%0d", n));
            for (int j = 0; j < 6; j++) begin
                r = 4'($urandom_range(0, 15));
                do_read(r, (r > 4'd10) ? 128'h0 : ref_rk[r], $sformatf("rnd%0d_rd%0d", n, r));
            end
        end

        // Restart from READY with a colliding read
        k_hold       = kif.rk_out;
        kif.key_in   = 128'h000102030405060708090a0b0c0d0e0f;
        kif.start    = 1'b1;
        kif.rd_en    = 1'b1;
        kif.rd_round = 4'd3;
        step();
        kif.start    = 1'b0;
        kif.rd_en    = 1'b0;
        chk1("restart_valid", kif.rk_valid, 1'b0);
        chk1("restart_key_ready", kif.key_ready, 1'b0);
        chk1("restart_busy", kif.busy, 1'b1);
        chk("restart_hold", kif.rk_out, k_hold);
        for (int c = 1; c <= 10; c++) begin
            step();
            chk1($sformatf("restart_done_t%0d", c), kif.done, c == 10);
        end
        do_read(4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5, "restart_rd10");

        // Asynchronous reset in the middle of expansion
        kif.key_in = {$urandom, $urandom, $urandom, $urandom};
        kif.start  = 1'b1;
        step();
        kif.start  = 1'b0;
        for (int c = 1; c <= 4; c++) step();
        #2;
        rst = 1'b1;
        #1;
        chk1("arst_busy", kif.busy, 1'b0);
        chk1("arst_done", kif.done, 1'b0);
        chk1("arst_key_ready", kif.key_ready, 1'b0);
        chk1("arst_rk_valid", kif.rk_valid, 1'b0);
        chk("arst_rk_out", kif.rk_out, 128'h0);
        step();
        rst = 1'b0;
        for (int c = 0; c < 12; c++) step();
        chk1("arst_no_ready", kif.key_ready, 1'b0);
        chk1("arst_no_busy", kif.busy, 1'b0);
        kif.rd_en    = 1'b1;
        kif.rd_round = 4'd1;
        step();
        kif.rd_en    = 1'b0;
        chk1("arst_idle_read", kif.rk_valid, 1'b0);
        chk("arst_slot1", dut.slot_q[1], 128'h0);

`ifdef KEYSCHED_ZEROIZE_EN
        run_expand(128'h2b7e151628aed2a6abf7158809cf4f3c, "zpre");
        kif.zeroize = 1'b1;
        step();
        kif.zeroize = 1'b0;
        chk1("zero_ready", kif.key_ready, 1'b0);
        chk1("zero_busy", kif.busy, 1'b0);
        chk("zero_rk_out", kif.rk_out, 128'h0);
        kif.key_in = {$urandom, $urandom, $urandom, $urandom};
        kif.start  = 1'b1;
        step();
        kif.start  = 1'b0;
        step();
        step();
        kif.zeroize = 1'b1;
        step();
        kif.zeroize = 1'b0;
        chk1("zero_t3_busy", kif.busy, 1'b0);
        kif.rd_en    = 1'b1;
        kif.rd_round = 4'd1;
        step();
        kif.rd_en    = 1'b0;
        chk1("zero_rd_rejected", kif.rk_valid, 1'b0);
        for (int i = 0; i <= 10; i++) chk($sformatf("zero_slot%0d", i), dut.slot_q[i], 128'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
